// File: rtl/serial_fa_sequencer.sv
// Bit-serial add/subtract controller driving one external full-adder cell.
// Operands are streamed LSB first; result, carry-out and overflow are registered.
module serial_fa_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             accept;
    logic             running;
    logic             last;

    assign running = (state == RUN);
    assign accept  = start_valid && (state == IDLE);
    assign last    = (cnt_q == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_valid) state_nxt = RUN;
            RUN:  if (last)        state_nxt = DONE;
            DONE: if (done_ready)  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Operand load, bit-serial shifting and final flag capture
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= op_a;
            b_q     <= sub ? ~op_b : op_b;
            carry_q <= sub;
            cnt_q   <= '0;
            res_q   <= '0;
        end else if (running) begin
            a_q     <= {1'b0, a_q[WIDTH-1:1]};
            b_q     <= {1'b0, b_q[WIDTH-1:1]};
            res_q   <= {fa_sum, res_q[WIDTH-1:1]};
            carry_q <= fa_cout;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                // carry into the MSB is the cell's cin on this final bit
                cout_q <= fa_cout;
                ovf_q  <= carry_q ^ fa_cout;
            end
        end
    end

    // Handshake and adder-cell drive decoded from state and registers
    assign start_ready = (state == IDLE);
    assign done_valid  = (state == DONE);
    assign fa_a        = running & a_q[0];
    assign fa_b        = running & b_q[0];
    assign fa_cin      = running & carry_q;
    assign result      = res_q;
    assign carry_out   = cout_q;
    assign overflow    = ovf_q;

endmodule
